// File: rtl/enc_8_3_irq.sv
// Sequential 8-to-3 priority encoder with a masked interrupt handshake.
// Requests latch into pending, the lowest eligible index is presented on irq/code, then ack/eoi.
module enc_8_3_irq #(
    parameter bit DETECT_EDGE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       mask_we,
    input  logic [7:0] mask_in,
    output logic [7:0] mask,
    output logic       irq,
    output logic [2:0] code,
    input  logic       ack,
    input  logic       eoi,
    output logic       in_service,
    output logic [7:0] pending,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, mask_q, req_q;
    logic [7:0] set_bits, clr_bits, eligible;
    logic [2:0] code_q, code_d, winner;
    logic       irq_q, irq_d, in_service_q, in_service_d;

    // Handshake: irq/code offer a request; ack while irq=1 takes it and clears its
    // pending bit; in_service then holds until eoi. ack/eoi outside their state are ignored.

    assign set_bits = DETECT_EDGE ? (req & ~req_q) : req;
    assign eligible = pending_q & ~mask_q;

    always_comb begin
        clr_bits = 8'h00;
        if (state_q == PRESENT && ack) begin
            clr_bits[code_q] = 1'b1;
        end
    end

    // Scanning downward leaves the lowest set index as the winner.
    always_comb begin
        winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (eligible != 8'h00) begin
                    state_d = PRESENT;
                    code_d  = winner;
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_d = SERVICE;
                end else if (mask_q[code_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        irq_d        = (state_d == PRESENT);
        in_service_d = (state_d == SERVICE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= 8'h00;
            mask_q       <= 8'hFF;
            req_q        <= 8'h00;
            code_q       <= 3'd0;
            irq_q        <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            // Set after clear so a same-cycle re-request survives the ack.
            pending_q    <= (pending_q & ~clr_bits) | set_bits;
            req_q        <= req;
            code_q       <= code_d;
            irq_q        <= irq_d;
            in_service_q <= in_service_d;
            if (mask_we) begin
                mask_q <= mask_in;
            end
        end
    end

    assign mask       = mask_q;
    assign pending    = pending_q;
    assign irq        = irq_q;
    assign code       = code_q;
    assign in_service = in_service_q;
    assign state      = state_q;

endmodule

// File: doc/enc_8_3_irq.md
Name: enc_8_3_irq

Overview:
Sequential 8-to-3 priority encoder and interrupt controller. It is the encode-side counterpart of the 3-to-8 decoder used in the control unit. It collects eight request lines, applies a write-able mask, and presents the winning request as a 3-bit code with an irq/ack/eoi handshake. It sits between the I/O flag logic and the control sequencer; the sequencer acks the request, uses the code, and signals end-of-interrupt.

Parameters:
DETECT_EDGE, 1, 1 = a request latches on a 0->1 transition of req[i]; 0 = latches on level high, sampled every cycle.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
req  input  8  request lines; req[0] has highest priority, req[7] lowest
mask_we  input  1  write strobe for mask register
mask_in  input  8  new mask value; bit=1 masks that request
mask  output  8  current mask register
irq  output  1  interrupt request to sequencer
code  output  3  encoded index of the presented request; valid while irq or in_service is 1
ack  input  1  sequencer accepts the presented request
eoi  input  1  end of interrupt service
in_service  output  1  high from ack until eoi
pending  output  8  latched, not-yet-acknowledged requests

Behaviour:
- Reset (rst=1 at a clock edge): pending=8'h00, mask=8'hFF, irq=0, code=3'd0, in_service=0, state=IDLE, edge-capture register req_q=8'h00. Reset mid-handshake aborts it with no residue.
- Request capture, every cycle:
  - DETECT_EDGE=1: pending <= (pending & ~clr) | (req & ~req_q); req_q <= req.
  - DETECT_EDGE=0: pending <= (pending & ~clr) | req.
  - clr is the one-hot clear issued on ack.
  - If set and clear hit the same bit in the same cycle, set wins.
  - A req held high through reset release counts as an edge on the first cycle after reset.
- Masking only gates presentation. pending bits still latch while masked.
- mask_we=1: mask <= mask_in at the edge. The new mask takes effect from the following cycle's evaluation.
- Encoding: eligible = pending & ~mask. The winner is the lowest set index of eligible. The encode is combinational from the registered pending/mask; the result is registered into code.
- FSM with three states: IDLE, PRESENT, SERVICE.
  - IDLE: irq=0. If eligible != 0: code <= winner, go to PRESENT.
  - PRESENT: irq=1 and code is held stable, even if a higher-priority request arrives.
    - If ack=1: clear pending[code], in_service <= 1, irq <= 0, go to SERVICE.
    - Else if mask[code]=1 (masked after presentation): withdraw, irq <= 0, go to IDLE.
    - Ack has priority over a same-cycle mask write.
  - SERVICE: irq=0, in_service=1, code held.
    - If eoi=1: in_service <= 0, go to IDLE.
    - No nesting: new requests accumulate in pending and are arbitrated after returning to IDLE.
- Ignored inputs: ack in IDLE or SERVICE, and eoi in IDLE or PRESENT, are ignored with no state change.
- Latency:
  - req[i] is first sampled high at edge k, so pending[i]=1 after edge k.
  - With mask[i]=0 and state IDLE, irq=1 and code=i after edge k+1.
  - ack sampled at edge m gives irq=0 and in_service=1 after edge m.
  - eoi at edge n gives IDLE after n. The earliest re-presentation is after edge n+1.
- All outputs are registered except mask and pending, which are register contents driven directly.

Test Plan:
- Reset, then mask_in=8'h00 with mask_we pulsed; raise req=8'h20 for 1 cycle -> pending=8'h20 after the next edge, irq=1 and code=5 one edge later; ack 1 cycle -> pending=8'h00, irq=0, in_service=1; eoi -> in_service=0, state IDLE.
- Priority: req=8'h88 in the same cycle -> code=3; ack, eoi -> then code=7 presented 2 edges after eoi.
- Stability: present code=6, then raise req[1] before ack -> code stays 6 until ack; after eoi, code=1 presented.
- Masking: mask=8'hFF, req[2] edge -> pending=8'h04, irq stays 0; write mask=8'hFB -> irq=1, code=2; write mask=8'hFF while in PRESENT without ack -> irq drops next edge, pending still 8'h04.
- Set-vs-clear: DETECT_EDGE=0, req[4] held high, ack on code=4 -> pending[4] remains 1 and is re-presented after eoi.
- Reset mid-operation: assert rst in SERVICE with pending=8'h11 -> all outputs at reset values next edge; spurious ack/eoi in IDLE -> no change.
